// File: rtl/alu_dispatch_pkg.sv
// Shared types and constants for the ALU dispatcher: FSM state encoding,
// decoded ALU operation codes, and default timing parameters.
package alu_dispatch_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ARM     = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam int ALU_LATENCY_DEF = 32'd4;
  localparam int TIMEOUT_CYC_DEF = 32'd16;

  // Decoded ALU operation codes; 0..5 are branch compares, 6..15 arithmetic/logic
  localparam logic [4:0] INSTR_BEQ     = 5'd0;
  localparam logic [4:0] INSTR_BNE     = 5'd1;
  localparam logic [4:0] INSTR_BLT     = 5'd2;
  localparam logic [4:0] INSTR_BGE     = 5'd3;
  localparam logic [4:0] INSTR_BLTU    = 5'd4;
  localparam logic [4:0] INSTR_BGEU    = 5'd5;
  localparam logic [4:0] INSTR_ADD     = 5'd6;
  localparam logic [4:0] INSTR_SUB     = 5'd7;
  localparam logic [4:0] INSTR_SLL     = 5'd8;
  localparam logic [4:0] INSTR_SLT     = 5'd9;
  localparam logic [4:0] INSTR_SLTU    = 5'd10;
  localparam logic [4:0] INSTR_XOR     = 5'd11;
  localparam logic [4:0] INSTR_SRL     = 5'd12;
  localparam logic [4:0] INSTR_SRA     = 5'd13;
  localparam logic [4:0] INSTR_OR      = 5'd14;
  localparam logic [4:0] INSTR_AND     = 5'd15;
  localparam logic [4:0] INSTR_INVALID = 5'd16;

  // Any code from INSTR_INVALID upward is rejected locally without using the ALU
  function automatic logic instr_is_valid(input logic [4:0] instr);
    return (instr < INSTR_INVALID);
  endfunction

endpackage

// File: rtl/alu_dispatch.sv
// ALU dispatcher: accepts one decoded request, drives the ALU operand bus,
// pulses dat_ready for the ALU latency, captures result/flags and returns
// them over a valid/ready response channel. One operation in flight.
// Optional feature macro ALU_DISPATCH_READY_HS_EN: completion waits for
// ALU_ready (with a TIMEOUT_CYC bound) instead of a fixed latency count.
module alu_dispatch
  import alu_dispatch_pkg::*;
#(
  parameter int ALU_LATENCY = ALU_LATENCY_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        soc_clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_dat1,
  input  logic [31:0] req_dat2,
  input  logic [2:0]  req_opcode,
  input  logic        req_differentiator,
  input  logic        req_optype,
  input  logic [4:0]  req_instr,
  output logic [31:0] ALU_dat1,
  output logic [31:0] ALU_dat2,
  output logic [2:0]  ALU_opcode,
  output logic        ALU_opcode_differentiator,
  output logic        ALU_optype,
  output logic [4:0]  Instruction_to_ALU,
  output logic        dat_ready,
  input  logic [31:0] ALU_out,
  input  logic        ALU_overflow,
  input  logic        ALU_con_met,
  input  logic        ALU_zero,
  input  logic        ALU_err,
  input  logic        ALU_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_overflow,
  output logic        rsp_con_met,
  output logic        rsp_zero,
  output logic        rsp_err
);

  // Counter is sized for whichever completion bound is larger so either build fits
  localparam int CNT_MAX = (ALU_LATENCY > TIMEOUT_CYC) ? ALU_LATENCY : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 32'sd1);

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               tmo_r, tmo_s;
  logic               req_ready_s, dat_ready_s, rsp_valid_s;
  logic [31:0]        alu_dat1_s, alu_dat2_s, rsp_result_s;
  logic [2:0]         alu_opcode_s;
  logic               alu_diff_s, alu_optype_s;
  logic [4:0]         alu_instr_s;
  logic               rsp_overflow_s, rsp_con_met_s, rsp_zero_s, rsp_err_s;

`ifndef ALU_DISPATCH_READY_HS_EN
  logic unused_alu_ready_s;
  assign unused_alu_ready_s = ALU_ready;
`endif

  // Next-state and next-output logic; every register holds unless a state changes it
  always_comb begin
    state_s        = state_r;
    cnt_s          = cnt_r;
    tmo_s          = tmo_r;
    req_ready_s    = req_ready;
    dat_ready_s    = dat_ready;
    rsp_valid_s    = rsp_valid;
    alu_dat1_s     = ALU_dat1;
    alu_dat2_s     = ALU_dat2;
    alu_opcode_s   = ALU_opcode;
    alu_diff_s     = ALU_opcode_differentiator;
    alu_optype_s   = ALU_optype;
    alu_instr_s    = Instruction_to_ALU;
    rsp_result_s   = rsp_result;
    rsp_overflow_s = rsp_overflow;
    rsp_con_met_s  = rsp_con_met;
    rsp_zero_s     = rsp_zero;
    rsp_err_s      = rsp_err;

    case (state_r)
      IDLE: begin
        if (req_valid && req_ready) begin
          req_ready_s = 1'b0;
          if (instr_is_valid(req_instr)) begin
            alu_dat1_s   = req_dat1;
            alu_dat2_s   = req_dat2;
            alu_opcode_s = req_opcode;
            alu_diff_s   = req_differentiator;
            alu_optype_s = req_optype;
            alu_instr_s  = req_instr;
            state_s      = SETUP;
          end else begin
            // Invalid op: the ALU bus is left untouched, respond with a local error
            rsp_result_s   = 32'd0;
            rsp_overflow_s = 1'b0;
            rsp_con_met_s  = 1'b0;
            rsp_zero_s     = 1'b0;
            rsp_err_s      = 1'b1;
            state_s        = RESP;
          end
        end else begin
          req_ready_s = 1'b1;
        end
      end
      SETUP: begin
        dat_ready_s = 1'b1;
        cnt_s       = {CNT_W{1'b0}};
        tmo_s       = 1'b0;
        state_s     = ARM;
      end
      ARM: begin
`ifdef ALU_DISPATCH_READY_HS_EN
        if (ALU_ready) begin
          dat_ready_s = 1'b0;
          state_s     = CAPTURE;
        end else if (cnt_r == CNT_W'(TIMEOUT_CYC - 32'sd1)) begin
          dat_ready_s = 1'b0;
          tmo_s       = 1'b1;
          state_s     = CAPTURE;
        end else begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
`else
        if (cnt_r == CNT_W'(ALU_LATENCY - 32'sd1)) begin
          dat_ready_s = 1'b0;
          state_s     = CAPTURE;
        end else begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
`endif
      end
      CAPTURE: begin
        if (tmo_r) begin
          rsp_result_s   = 32'd0;
          rsp_overflow_s = 1'b0;
          rsp_con_met_s  = 1'b0;
          rsp_zero_s     = 1'b0;
          rsp_err_s      = 1'b1;
        end else begin
          rsp_result_s   = ALU_out;
          rsp_overflow_s = ALU_overflow;
          rsp_con_met_s  = ALU_con_met;
          rsp_zero_s     = ALU_zero;
          rsp_err_s      = ALU_err;
        end
        rsp_valid_s = 1'b1;
        state_s     = RESP;
      end
      RESP: begin
        // The invalid-op path enters with rsp_valid low; it is raised here one cycle later
        if (rsp_valid && rsp_ready) begin
          rsp_valid_s = 1'b0;
          req_ready_s = 1'b1;
          state_s     = IDLE;
        end else begin
          rsp_valid_s = 1'b1;
        end
      end
      default: begin
        state_s     = IDLE;
        req_ready_s = 1'b1;
        dat_ready_s = 1'b0;
        rsp_valid_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs; synchronous reset abandons any operation in flight
  always_ff @(posedge soc_clk) begin
    if (reset) begin
      state_r                   <= IDLE;
      cnt_r                     <= {CNT_W{1'b0}};
      tmo_r                     <= 1'b0;
      req_ready                 <= 1'b1;
      dat_ready                 <= 1'b0;
      rsp_valid                 <= 1'b0;
      ALU_dat1                  <= 32'd0;
      ALU_dat2                  <= 32'd0;
      ALU_opcode                <= 3'd0;
      ALU_opcode_differentiator <= 1'b0;
      ALU_optype                <= 1'b0;
      Instruction_to_ALU        <= 5'd0;
      rsp_result                <= 32'd0;
      rsp_overflow              <= 1'b0;
      rsp_con_met               <= 1'b0;
      rsp_zero                  <= 1'b0;
      rsp_err                   <= 1'b0;
    end else begin
      state_r                   <= state_s;
      cnt_r                     <= cnt_s;
      tmo_r                     <= tmo_s;
      req_ready                 <= req_ready_s;
      dat_ready                 <= dat_ready_s;
      rsp_valid                 <= rsp_valid_s;
      ALU_dat1                  <= alu_dat1_s;
      ALU_dat2                  <= alu_dat2_s;
      ALU_opcode                <= alu_opcode_s;
      ALU_opcode_differentiator <= alu_diff_s;
      ALU_optype                <= alu_optype_s;
      Instruction_to_ALU        <= alu_instr_s;
      rsp_result                <= rsp_result_s;
      rsp_overflow              <= rsp_overflow_s;
      rsp_con_met               <= rsp_con_met_s;
      rsp_zero                  <= rsp_zero_s;
      rsp_err                   <= rsp_err_s;
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed self-checking bench for alu_dispatch (default build).
// A small ALU stand-in presents the hand-computed result only after
// dat_ready has been high for 4 edges, so early or late capture shows up.
module tb_alu_dispatch;

  logic        soc_clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_dat1, req_dat2;
  logic [2:0]  req_opcode;
  logic        req_differentiator, req_optype;
  logic [4:0]  req_instr;
  logic [31:0] ALU_dat1, ALU_dat2;
  logic [2:0]  ALU_opcode;
  logic        ALU_opcode_differentiator, ALU_optype;
  logic [4:0]  Instruction_to_ALU;
  logic        dat_ready;
  logic [31:0] ALU_out;
  logic        ALU_overflow, ALU_con_met, ALU_zero, ALU_err, ALU_ready;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_overflow, rsp_con_met, rsp_zero, rsp_err;

  int n_cmp = 0;
  int n_err = 0;

  alu_dispatch dut (
    .soc_clk(soc_clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dat1(req_dat1), .req_dat2(req_dat2), .req_opcode(req_opcode),
    .req_differentiator(req_differentiator), .req_optype(req_optype), .req_instr(req_instr),
    .ALU_dat1(ALU_dat1), .ALU_dat2(ALU_dat2), .ALU_opcode(ALU_opcode),
    .ALU_opcode_differentiator(ALU_opcode_differentiator), .ALU_optype(ALU_optype),
    .Instruction_to_ALU(Instruction_to_ALU), .dat_ready(dat_ready),
    .ALU_out(ALU_out), .ALU_overflow(ALU_overflow), .ALU_con_met(ALU_con_met),
    .ALU_zero(ALU_zero), .ALU_err(ALU_err), .ALU_ready(ALU_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_con_met(rsp_con_met), .rsp_zero(rsp_zero),
    .rsp_err(rsp_err)
  );

  always #5 soc_clk = ~soc_clk;

  // ALU stand-in: outputs are only meaningful once dat_ready has been seen on 4 edges
  logic [31:0] alu_res;
  logic        alu_ovf, alu_con, alu_zro, alu_er;
  logic [3:0]  hi_cnt = 4'd0;
  always @(posedge soc_clk) hi_cnt <= dat_ready ? hi_cnt + 4'd1 : 4'd0;
  assign ALU_out      = (hi_cnt >= 4'd4) ? alu_res : 32'hDEADBEEF;
  assign ALU_overflow = (hi_cnt >= 4'd4) & alu_ovf;
  assign ALU_con_met  = (hi_cnt >= 4'd4) & alu_con;
  assign ALU_zero     = (hi_cnt >= 4'd4) & alu_zro;
  assign ALU_err      = (hi_cnt >= 4'd4) & alu_er;
  assign ALU_ready    = 1'b0;

  // dat_ready pulse monitor: longest high run and shortest low gap between pulses
  int hi_run = 0, lo_run = 0, max_hi = 0, min_gap = 1000;
  bit seen_pulse = 1'b0;
  always @(negedge soc_clk) begin
    if (dat_ready === 1'b1) begin
      if (hi_run == 0 && seen_pulse && lo_run < min_gap) min_gap = lo_run;
      hi_run = hi_run + 1;
      if (hi_run > max_hi) max_hi = hi_run;
      lo_run = 0;
      seen_pulse = 1'b1;
    end else begin
      hi_run = 0;
      lo_run = lo_run + 1;
    end
  end

  task automatic tick();
    @(posedge soc_clk);
    @(negedge soc_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request for a single edge (E0)
  task automatic present(input logic [4:0] instr, input logic [31:0] d1, input logic [31:0] d2,
                         input logic optype, input logic [2:0] opc, input logic diff);
    req_instr = instr; req_dat1 = d1; req_dat2 = d2;
    req_optype = optype; req_opcode = opc; req_differentiator = diff;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Edges after E0 until rsp_valid is seen (bounded), plus dat_ready-high samples
  int lat, hi;
  task automatic wait_rsp();
    lat = 0; hi = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
      if (dat_ready === 1'b1) hi++;
    end
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_hs_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_hs_req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  bit bp_ok;

  initial begin
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_dat1 = 32'd0; req_dat2 = 32'd0; req_opcode = 3'd0;
    req_differentiator = 1'b0; req_optype = 1'b0; req_instr = 5'd0;
    alu_res = 32'd0; alu_ovf = 1'b0; alu_con = 1'b0; alu_zro = 1'b0; alu_er = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_dat_ready", {31'd0, dat_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_alu_dat1", ALU_dat1, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    reset = 1'b0;
    tick();

    // ADD 5+7
    alu_res = 32'd12; alu_ovf = 1'b0; alu_con = 1'b0; alu_zro = 1'b0; alu_er = 1'b0;
    present(5'd6, 32'd5, 32'd7, 1'b1, 3'd0, 1'b0);
    chk("add_req_ready", {31'd0, req_ready}, 32'd0);
    chk("add_setup_dat_ready", {31'd0, dat_ready}, 32'd0);
    chk("add_alu_dat1", ALU_dat1, 32'd5);
    chk("add_alu_dat2", ALU_dat2, 32'd7);
    chk("add_instr", {27'd0, Instruction_to_ALU}, 32'd6);
    wait_rsp();
    chk("add_latency", lat, 32'd6);
    chk("add_dat_ready_cycles", hi, 32'd4);
    chk("add_result", rsp_result, 32'd12);
    chk("add_flags", {28'd0, rsp_overflow, rsp_con_met, rsp_zero, rsp_err}, 32'd0);
    handshake("add");

    // SUB overflow 0x80000000 - 1
    alu_res = 32'h7FFFFFFF; alu_ovf = 1'b1; alu_con = 1'b0; alu_zro = 1'b0; alu_er = 1'b0;
    present(5'd7, 32'h80000000, 32'd1, 1'b1, 3'd0, 1'b1);
    chk("sub_diff", {31'd0, ALU_opcode_differentiator}, 32'd1);
    wait_rsp();
    chk("sub_latency", lat, 32'd6);
    chk("sub_result", rsp_result, 32'h7FFFFFFF);
    chk("sub_overflow", {31'd0, rsp_overflow}, 32'd1);
    chk("sub_err", {31'd0, rsp_err}, 32'd0);
    handshake("sub");

    // BEQ 0x1234 == 0x1234
    alu_res = 32'd0; alu_ovf = 1'b0; alu_con = 1'b1; alu_zro = 1'b1; alu_er = 1'b0;
    present(5'd0, 32'h1234, 32'h1234, 1'b0, 3'd0, 1'b0);
    chk("beq_optype", {31'd0, ALU_optype}, 32'd0);
    wait_rsp();
    chk("beq_latency", lat, 32'd6);
    chk("beq_con_met", {31'd0, rsp_con_met}, 32'd1);
    chk("beq_result", rsp_result, 32'd0);
    handshake("beq");

    // Invalid op: local error, ALU bus untouched, no dat_ready
    alu_res = 32'hFFFFFFFF; alu_ovf = 1'b1; alu_con = 1'b1; alu_zro = 1'b1; alu_er = 1'b0;
    present(5'd16, 32'hAAAA5555, 32'h5555AAAA, 1'b1, 3'd1, 1'b0);
    chk("inv_valid_e0", {31'd0, rsp_valid}, 32'd0);
    wait_rsp();
    chk("inv_latency", lat, 32'd1);
    chk("inv_dat_ready", hi, 32'd0);
    chk("inv_err", {31'd0, rsp_err}, 32'd1);
    chk("inv_result", rsp_result, 32'd0);
    chk("inv_flags", {29'd0, rsp_overflow, rsp_con_met, rsp_zero}, 32'd0);
    chk("inv_alu_untouched", ALU_dat1, 32'h1234);
    handshake("inv");

    // Backpressure: AND 0xFF & 0x55 held for 10 cycles with a new request waiting
    alu_res = 32'h55; alu_ovf = 1'b0; alu_con = 1'b0; alu_zro = 1'b0; alu_er = 1'b0;
    present(5'd15, 32'hFF, 32'h55, 1'b1, 3'd7, 1'b0);
    wait_rsp();
    chk("bp_latency", lat, 32'd6);
    req_instr = 5'd6; req_dat1 = 32'd100; req_dat2 = 32'd23;
    req_optype = 1'b1; req_opcode = 3'd0; req_differentiator = 1'b0;
    req_valid = 1'b1;
    bp_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_result !== 32'h55 || req_ready !== 1'b0 ||
          dat_ready !== 1'b0 || rsp_err !== 1'b0) bp_ok = 1'b0;
    end
    chk("bp_stable", {31'd0, bp_ok}, 32'd1);
    alu_res = 32'd123;
    handshake("bp");
    chk("bp_not_yet_taken", ALU_dat1, 32'hFF);
    tick();
    req_valid = 1'b0;
    chk("b2b_accepted", ALU_dat1, 32'd100);
    chk("b2b_req_ready", {31'd0, req_ready}, 32'd0);
    wait_rsp();
    chk("b2b_latency", lat, 32'd6);
    chk("b2b_result", rsp_result, 32'd123);
    handshake("b2b");
    chk("gap_min", {31'd0, (min_gap >= 3)}, 32'd1);
    chk("pulse_max", max_hi, 32'd4);

    // Reset during the second dat_ready cycle
    alu_res = 32'd99;
    present(5'd6, 32'd9, 32'd90, 1'b1, 3'd0, 1'b0);
    tick();
    tick();
    chk("rmid_dat_ready_on", {31'd0, dat_ready}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmid_dat_ready", {31'd0, dat_ready}, 32'd0);
    chk("rmid_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rmid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rmid_alu_bus", {ALU_dat1 | ALU_dat2}, 32'd0);
    chk("rmid_alu_ctl", {22'd0, ALU_opcode, ALU_opcode_differentiator, ALU_optype, Instruction_to_ALU}, 32'd0);
    chk("rmid_rsp", {rsp_result | {28'd0, rsp_overflow, rsp_con_met, rsp_zero, rsp_err}}, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("rmid_no_rsp", {31'd0, rsp_valid}, 32'd0);

    // ADD 1+1 after the abandoned operation
    alu_res = 32'd2; alu_ovf = 1'b0; alu_con = 1'b0; alu_zro = 1'b0; alu_er = 1'b0;
    present(5'd6, 32'd1, 32'd1, 1'b1, 3'd0, 1'b0);
    wait_rsp();
    chk("post_rst_latency", lat, 32'd6);
    chk("post_rst_result", rsp_result, 32'd2);
    handshake("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
